mem_io_responder: RTL and testbench

- Responder end of the CPU byte-wide memory bus (mem_a / mem_dout / mem_wr out of the CPU, mem_din / io_buffer_full into it).
- Implements the 128 KB RAM plus the memory-mapped I/O page at mem_a[17:16]==2'b11.
- Returns read data one cycle after the address and buffers UART output bytes in a TX FIFO.
- Provides the stdin byte port, the free-running clock counter and the program-stop indication.

---
 rtl/mem_io_responder_pkg.sv | 20 ++
 rtl/mem_io_responder_io_tx_fifo.sv | 84 ++++++++
 rtl/mem_io_responder.sv | 165 ++++++++++++++++
 tb/tb_mem_io_responder.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants and types for the CPU memory-bus responder.
//   IO_PAGE  : value of mem_a[17:16] that selects the I/O page
//   IO_UART  : I/O offset of the UART data register (read stdin / write stdout)
//   IO_CLK   : I/O offset of the clock counter (read) / program stop (write)
//   BYTE_LEN : width of the data bus
package mem_io_responder_pkg;

  localparam logic [1:0] IO_PAGE  = 2'b11;
  localparam logic [2:0] IO_UART  = 3'd0;
  localparam logic [2:0] IO_CLK   = 3'd4;
  localparam int         BYTE_LEN = 8;

  // Source selected by the output mux in the cycle after a bus access.
  typedef enum logic [1:0] {
    SRC_HOLD = 2'd0,
    SRC_RAM  = 2'd1,
    SRC_IO   = 2'd2
  } rd_src_e;

endpackage

// File: rtl/mem_io_responder_io_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
//   clk, rst    : clock, asynchronous active-high reset
//   push        : enqueue request; push_data is the byte
//   pop         : dequeue request (ignored when empty)
//   head        : byte at the head of the queue
//   valid       : queue non-empty (registered)
//   nearly_full : queue holds DEPTH-1 or more entries (registered)
//   drop        : a push was refused this cycle because the queue was full
module io_tx_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [BYTE_LEN-1:0] push_data,
  input  logic                pop,
  output logic [BYTE_LEN-1:0] head,
  output logic                valid,
  output logic                nearly_full,
  output logic                drop
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [AW:0] NEAR_CNT = FULL_CNT - 1'b1;

  logic [BYTE_LEN-1:0] mem_r [DEPTH];
  logic [AW-1:0]       wr_ptr_r;
  logic [AW-1:0]       rd_ptr_r;
  logic [AW:0]         count_r;
  logic [AW:0]         count_next_s;
  logic                pop_ok_s;
  logic                push_ok_s;

  // Accept/refuse decision; a pop in the same cycle frees the slot for a push.
  always_comb begin
    pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});
    push_ok_s = push && ((count_r != FULL_CNT) || pop_ok_s);
    drop      = push && !push_ok_s;
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, count and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW+1){1'b0}};
      valid       <= 1'b0;
      nearly_full <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      count_r     <= count_next_s;
      valid       <= (count_next_s != {(AW+1){1'b0}});
      nearly_full <= (count_next_s >= NEAR_CNT);
    end
  end

  // Storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head = mem_r[rd_ptr_r];

endmodule

// File: rtl/mem_io_responder.sv
// Responder end of the CPU byte-wide memory bus: 128 KB RAM plus the I/O page
// at mem_a[17:16]==2'b11 (UART tx/rx, clock counter, program stop).
//   clk_in, rst_in       : clock, asynchronous active-high reset
//   mem_a/mem_dout/mem_wr: CPU address, write data, write strobe
//   mem_din              : read data, valid the cycle after the address
//   io_buffer_full       : TX FIFO holds TX_DEPTH-1 or more bytes
//   tx_data/tx_valid/tx_ready : TX FIFO head towards the UART
//   rx_data/rx_valid/rx_pop   : received byte and its consume pulse
//   program_stop         : sticky, set by a write to 0x30004
//   tx_overflow          : sticky, a UART byte was dropped
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8,
  parameter int TX_AW    = 3
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [31:0]         mem_a,
  input  logic [BYTE_LEN-1:0] mem_dout,
  input  logic                mem_wr,
  output logic [BYTE_LEN-1:0] mem_din,
  output logic                io_buffer_full,
  output logic [BYTE_LEN-1:0] tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [BYTE_LEN-1:0] rx_data,
  input  logic                rx_valid,
  output logic                rx_pop,
  output logic                program_stop,
  output logic                tx_overflow
);

  logic [BYTE_LEN-1:0] ram_r [2**RAM_AW];
  logic [BYTE_LEN-1:0] ram_q_r;
  logic [BYTE_LEN-1:0] io_q_r;
  logic [BYTE_LEN-1:0] din_hold_r;
  rd_src_e             rd_src_r;
  logic [31:0]         cycle_cnt_r;
  logic [31:8]         snap_hi_r;   // low byte is returned live, never from the snapshot

  logic [RAM_AW-1:0]   ram_idx_s;
  logic                io_s;
  logic                io_reg_s;
  logic [2:0]          io_off_s;
  logic                uart_rd_s;
  logic                clk_rd_s;
  logic                uart_wr_s;
  logic                stop_wr_s;
  logic [BYTE_LEN-1:0] io_rd_byte_s;
  logic                push_s;
  logic [BYTE_LEN-1:0] push_data_s;
  logic                pop_s;
  logic                drop_s;
  logic                unused_addr_s;

  assign unused_addr_s = ^mem_a[31:18];

  // Address decode; only the first eight bytes of the I/O page are registers.
  always_comb begin
    ram_idx_s = mem_a[RAM_AW-1:0];
    io_s      = (mem_a[17:16] == IO_PAGE);
    io_reg_s  = io_s && (mem_a[15:3] == 13'd0);
    io_off_s  = mem_a[2:0];
    uart_rd_s = !mem_wr && io_reg_s && (io_off_s == IO_UART);
    clk_rd_s  = !mem_wr && io_reg_s && (io_off_s == IO_CLK);
    uart_wr_s = mem_wr && io_reg_s && (io_off_s == IO_UART);
    stop_wr_s = mem_wr && io_reg_s && (io_off_s == IO_CLK);
  end

  // I/O read data captured at the access edge.
  always_comb begin
    io_rd_byte_s = 8'h00;
    if (io_reg_s) begin
      case (io_off_s)
        IO_UART:       io_rd_byte_s = rx_valid ? rx_data : 8'h00;
        IO_CLK:        io_rd_byte_s = cycle_cnt_r[7:0];
        IO_CLK + 3'd1: io_rd_byte_s = snap_hi_r[15:8];
        IO_CLK + 3'd2: io_rd_byte_s = snap_hi_r[23:16];
        IO_CLK + 3'd3: io_rd_byte_s = snap_hi_r[31:24];
        default:       io_rd_byte_s = 8'h00;
      endcase
    end else begin
      io_rd_byte_s = 8'h00;
    end
  end

  // TX FIFO request: zero bytes to the UART port are ignored, a stop write enqueues a 0x00 marker.
  always_comb begin
    push_s      = (uart_wr_s && (mem_dout != 8'h00)) || stop_wr_s;
    push_data_s = stop_wr_s ? 8'h00 : mem_dout;
    pop_s       = tx_valid && tx_ready;
  end

  // RAM write port and synchronous read port.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_s) begin
      ram_r[ram_idx_s] <= mem_dout;
    end
    ram_q_r <= ram_r[ram_idx_s];
  end

  // Read pipeline, counter/snapshot, stdin pop pulse and sticky flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_src_r      <= SRC_HOLD;
      io_q_r        <= 8'h00;
      din_hold_r    <= 8'h00;
      cycle_cnt_r   <= 32'd0;
      snap_hi_r     <= 24'd0;
      rx_pop        <= 1'b0;
      program_stop  <= 1'b0;
      tx_overflow   <= 1'b0;
    end else begin
      if (mem_wr) begin
        rd_src_r <= SRC_HOLD;
      end else if (io_s) begin
        rd_src_r <= SRC_IO;
      end else begin
        rd_src_r <= SRC_RAM;
      end
      io_q_r      <= io_rd_byte_s;
      din_hold_r  <= mem_din;
      cycle_cnt_r <= cycle_cnt_r + 32'd1;
      // Freeze the upper bytes so 0x30005..7 match the 0x30004 read.
      if (clk_rd_s) begin
        snap_hi_r <= cycle_cnt_r[31:8];
      end
      rx_pop <= uart_rd_s && rx_valid;
      if (stop_wr_s) begin
        program_stop <= 1'b1;
      end
      if (drop_s) begin
        tx_overflow <= 1'b1;
      end
    end
  end

  // Output mux: last cycle's access type picks the source, otherwise hold.
  always_comb begin
    mem_din = din_hold_r;
    case (rd_src_r)
      SRC_RAM: mem_din = ram_q_r;
      SRC_IO:  mem_din = io_q_r;
      default: mem_din = din_hold_r;
    endcase
  end

  io_tx_fifo #(
    .DEPTH (TX_DEPTH),
    .AW    (TX_AW)
  ) u_tx_fifo (
    .clk         (clk_in),
    .rst         (rst_in),
    .push        (push_s),
    .push_data   (push_data_s),
    .pop         (pop_s),
    .head        (tx_data),
    .valid       (tx_valid),
    .nearly_full (io_buffer_full),
    .drop        (drop_s)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: directed scenarios plus a
// randomized run compared against a queue/array reference model.
module tb_mem_io_responder;

  logic        clk_in;
  logic        rst_in;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        program_stop;
  logic        tx_overflow;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0]  ram_m [int unsigned];
  logic [7:0]  q_m [$];
  logic [31:0] cnt_m;
  logic [31:0] snap_m;
  logic [7:0]  exp_din;
  logic        exp_pop;
  logic        exp_stop;
  logic        exp_ovf;
  int unsigned wr_list [$];

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_dout       (mem_dout),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Model of one clock edge, using the inputs currently driven.
  function automatic void model_step();
    bit          pop_v;
    bit          io_v;
    bit          reg_v;
    bit          push_v;
    int unsigned before_v;
    logic [7:0]  pdata_v;
    logic [2:0]  off_v;
    int unsigned idx_v;
    pop_v   = (q_m.size() != 0) && tx_ready;
    io_v    = (mem_a[17:16] == 2'b11);
    reg_v   = (mem_a[15:3] == 13'd0);
    off_v   = mem_a[2:0];
    idx_v   = int'(mem_a[16:0]);
    push_v  = 1'b0;
    pdata_v = 8'h00;
    exp_pop = 1'b0;
    if (!mem_wr) begin
      if (!io_v) exp_din = ram_m[idx_v];
      else if (!reg_v) exp_din = 8'h00;
      else begin
        case (off_v)
          3'd0: begin exp_din = rx_valid ? rx_data : 8'h00; exp_pop = rx_valid; end
          3'd4: begin exp_din = cnt_m[7:0]; snap_m = cnt_m; end
          3'd5: exp_din = snap_m[15:8];
          3'd6: exp_din = snap_m[23:16];
          3'd7: exp_din = snap_m[31:24];
          default: exp_din = 8'h00;
        endcase
      end
    end else begin
      if (!io_v) ram_m[idx_v] = mem_dout;
      else if (reg_v && off_v == 3'd0 && mem_dout != 8'h00) begin push_v = 1'b1; pdata_v = mem_dout; end
      else if (reg_v && off_v == 3'd4) begin push_v = 1'b1; pdata_v = 8'h00; exp_stop = 1'b1; end
    end
    before_v = q_m.size();
    if (pop_v) void'(q_m.pop_front());
    if (push_v) begin
      if (before_v == 8 && !pop_v) exp_ovf = 1'b1;
      else q_m.push_back(pdata_v);
    end
    cnt_m = cnt_m + 32'd1;
  endfunction

  task automatic drive(input logic [31:0] a, input logic [7:0] d, input logic wr);
    mem_a = a; mem_dout = d; mem_wr = wr;
  endtask

  // Ignored write to an unused I/O offset: no read, no side effects.
  task automatic idle();
    drive(32'h0003_0010, 8'h00, 1'b1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic reset_assert();
    #2 rst_in = 1'b1;
    q_m.delete();
    cnt_m = 32'd0; snap_m = 32'd0; exp_din = 8'h00;
    exp_pop = 1'b0; exp_stop = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic reset_release();
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
  endtask

  task automatic do_reset();
    idle(); tx_ready = 1'b0; rx_valid = 1'b0;
    reset_assert();
    reset_release();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (mem_din !== 8'h00) begin $display("FAIL reset_mem_din: got %02h want 00", mem_din); bad++; end
    total++; if (io_buffer_full !== 1'b0) begin $display("FAIL reset_buf_full: got %b want 0", io_buffer_full); bad++; end
    total++; if (tx_valid !== 1'b0) begin $display("FAIL reset_tx_valid: got %b want 0", tx_valid); bad++; end
    total++; if (rx_pop !== 1'b0) begin $display("FAIL reset_rx_pop: got %b want 0", rx_pop); bad++; end
    total++; if (program_stop !== 1'b0) begin $display("FAIL reset_stop: got %b want 0", program_stop); bad++; end
    total++; if (tx_overflow !== 1'b0) begin $display("FAIL reset_ovf: got %b want 0", tx_overflow); bad++; end
    // counter starts at 0 on the first edge after reset
    drive(32'h0003_0004, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'h00) begin $display("FAIL reset_counter: got %02h want 00", mem_din); bad++; end
  endtask

  task automatic test_ram();
    do_reset();
    drive(32'h0000_0010, 8'hA5, 1'b1); tick();
    total++; if (mem_din !== 8'h00) begin $display("FAIL ram_hold_after_write: got %02h want 00", mem_din); bad++; end
    drive(32'h0000_0010, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'hA5) begin $display("FAIL ram_read_10: got %02h want a5", mem_din); bad++; end
    drive(32'h0001_FFFF, 8'h3C, 1'b1); tick();
    drive(32'h0001_FFFF, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'h3C) begin $display("FAIL ram_read_1ffff: got %02h want 3c", mem_din); bad++; end
    idle(); tick();
    total++; if (mem_din !== 8'h3C) begin $display("FAIL ram_hold_idle: got %02h want 3c", mem_din); bad++; end
    wr_list.push_back(32'h10); wr_list.push_back(32'h1FFFF);
  endtask

  task automatic test_uart_tx();
    do_reset();
    drive(32'h0003_0000, 8'h41, 1'b1); tick();
    drive(32'h0003_0000, 8'h00, 1'b1); tick();
    drive(32'h0003_0000, 8'h42, 1'b1); tick();
    idle(); tick();
    total++; if (tx_valid !== 1'b1) begin $display("FAIL uart_valid: got %b want 1", tx_valid); bad++; end
    total++; if (tx_data !== 8'h41) begin $display("FAIL uart_head0: got %02h want 41", tx_data); bad++; end
    tx_ready = 1'b1; tick();
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin $display("FAIL uart_head1: got %b/%02h want 1/42", tx_valid, tx_data); bad++; end
    tick();
    total++; if (tx_valid !== 1'b0) begin $display("FAIL uart_empty: got %b want 0", tx_valid); bad++; end
    tx_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [7:0] want;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(32'h0003_0000, 8'(i + 1), 1'b1); tick();
      total++; if (io_buffer_full !== ((i + 1) >= 7)) begin $display("FAIL full_flag_%0d: got %b want %b", i + 1, io_buffer_full, (i + 1) >= 7); bad++; end
      total++; if (tx_overflow !== 1'b0) begin $display("FAIL full_no_ovf_%0d: got %b want 0", i + 1, tx_overflow); bad++; end
    end
    // push with pop while full
    tx_ready = 1'b1; drive(32'h0003_0000, 8'h55, 1'b1); tick();
    total++; if (tx_overflow !== 1'b0) begin $display("FAIL full_pushpop_ovf: got %b want 0", tx_overflow); bad++; end
    total++; if (io_buffer_full !== 1'b1 || tx_data !== 8'h02) begin $display("FAIL full_pushpop_state: got %b/%02h want 1/02", io_buffer_full, tx_data); bad++; end
    tx_ready = 1'b0; drive(32'h0003_0000, 8'h66, 1'b1); tick();
    total++; if (tx_overflow !== 1'b1) begin $display("FAIL full_drop_ovf: got %b want 1", tx_overflow); bad++; end
    idle(); tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      want = (k < 7) ? 8'(k + 2) : 8'h55;
      total++; if (tx_valid !== 1'b1 || tx_data !== want) begin $display("FAIL full_drain_%0d: got %b/%02h want 1/%02h", k, tx_valid, tx_data, want); bad++; end
      tick();
    end
    total++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin $display("FAIL full_drained: got %b/%b want 0/0", tx_valid, io_buffer_full); bad++; end
    tx_ready = 1'b0;
  endtask

  task automatic test_clock();
    int          n;
    logic [31:0] got;
    do_reset();
    n = $urandom_range(3, 40);
    for (int i = 0; i < n; i++) tick();
    for (int b = 0; b < 4; b++) begin
      drive(32'h0003_0004 + 32'(b), 8'h00, 1'b0); tick();
      got[b*8 +: 8] = mem_din;
    end
    total++; if (got !== 32'(n)) begin $display("FAIL clock_value: got %08h want %08h", got, 32'(n)); bad++; end
    // wrap: preload the counter with all ones
    force dut.cycle_cnt_r = 32'hFFFF_FFFF;
    #1 release dut.cycle_cnt_r;
    cnt_m = 32'hFFFF_FFFF;
    for (int b = 0; b < 4; b++) begin
      drive(32'h0003_0004 + 32'(b), 8'h00, 1'b0); tick();
      got[b*8 +: 8] = mem_din;
    end
    total++; if (got !== 32'hFFFF_FFFF) begin $display("FAIL clock_coherent: got %08h want ffffffff", got); bad++; end
    drive(32'h0003_0004, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'h03) begin $display("FAIL clock_wrap: got %02h want 03", mem_din); bad++; end
  endtask

  task automatic test_stdin();
    do_reset();
    rx_valid = 1'b1; rx_data = 8'h7A; drive(32'h0003_0000, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'h7A || rx_pop !== 1'b1) begin $display("FAIL stdin_read: got %02h/%b want 7a/1", mem_din, rx_pop); bad++; end
    rx_valid = 1'b0; idle(); tick();
    total++; if (rx_pop !== 1'b0 || mem_din !== 8'h7A) begin $display("FAIL stdin_pulse: got %02h/%b want 7a/0", mem_din, rx_pop); bad++; end
    drive(32'h0003_0000, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'h00 || rx_pop !== 1'b0) begin $display("FAIL stdin_empty: got %02h/%b want 00/0", mem_din, rx_pop); bad++; end
    drive(32'h0003_0002, 8'h00, 1'b0); tick();
    total++; if (mem_din !== 8'h00) begin $display("FAIL io_other_offset: got %02h want 00", mem_din); bad++; end
  endtask

  task automatic test_stop_reset();
    do_reset();
    drive(32'h0003_0004, 8'h99, 1'b1); tick();
    total++; if (program_stop !== 1'b1) begin $display("FAIL stop_set: got %b want 1", program_stop); bad++; end
    total++; if (tx_valid !== 1'b1 || tx_data !== 8'h00) begin $display("FAIL stop_marker: got %b/%02h want 1/00", tx_valid, tx_data); bad++; end
    drive(32'h0003_0000, 8'h61, 1'b1); tick();
    drive(32'h0000_0010, 8'h00, 1'b0); tick();
    total++; if (program_stop !== 1'b1 || mem_din !== 8'hA5) begin $display("FAIL stop_sticky: got %b/%02h want 1/a5", program_stop, mem_din); bad++; end
    reset_assert();
    #1;
    total++; if ({mem_din, io_buffer_full, tx_valid, rx_pop, program_stop, tx_overflow} !== 13'd0)
      begin $display("FAIL async_reset: got %02h %b%b%b%b%b want all zero", mem_din, io_buffer_full, tx_valid, rx_pop, program_stop, tx_overflow); bad++; end
    reset_release();
  endtask

  task automatic test_random();
    int          op;
    logic [31:0] a;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      a = $urandom;
      op = $urandom_range(0, 6);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tx_ready = ($urandom_range(0, 2) == 0);
      case (op)
        0: begin a[17] = 1'b0; drive(a, 8'($urandom), 1'b1); wr_list.push_back(int'(a[16:0])); end
        1: begin a[17:0] = 18'(wr_list[$urandom_range(0, wr_list.size() - 1)]); drive(a, 8'h00, 1'b0); end
        2: begin a[17:0] = 18'h3_0000; drive(a, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), 1'b1); end
        3: begin a[17:0] = 18'h3_0004; if ($urandom_range(0, 7) == 0) drive(a, 8'h00, 1'b1); else idle(); end
        4: begin a[17:0] = 18'h3_0000; drive(a, 8'h00, 1'b0); end
        5: begin a[17:0] = 18'h3_0004 + 18'($urandom_range(0, 3)); drive(a, 8'h00, 1'b0); end
        default: begin a[17:0] = 18'h3_0000 + 18'($urandom_range(1, 3)); drive(a, 8'h00, 1'b0); end
      endcase
      tick();
      total++; if (mem_din !== exp_din) begin $display("FAIL rnd_mem_din @%0d: got %02h want %02h", c, mem_din, exp_din); bad++; end
      total++; if (rx_pop !== exp_pop) begin $display("FAIL rnd_rx_pop @%0d: got %b want %b", c, rx_pop, exp_pop); bad++; end
      total++; if (tx_valid !== (q_m.size() != 0)) begin $display("FAIL rnd_tx_valid @%0d: got %b want %b", c, tx_valid, q_m.size() != 0); bad++; end
      if (q_m.size() != 0) begin
        total++; if (tx_data !== q_m[0]) begin $display("FAIL rnd_tx_data @%0d: got %02h want %02h", c, tx_data, q_m[0]); bad++; end
      end
      total++; if (io_buffer_full !== (q_m.size() >= 7)) begin $display("FAIL rnd_buf_full @%0d: got %b want %b", c, io_buffer_full, q_m.size() >= 7); bad++; end
      total++; if (tx_overflow !== exp_ovf) begin $display("FAIL rnd_ovf @%0d: got %b want %b", c, tx_overflow, exp_ovf); bad++; end
      total++; if (program_stop !== exp_stop) begin $display("FAIL rnd_stop @%0d: got %b want %b", c, program_stop, exp_stop); bad++; end
    end
    tx_ready = 1'b0; rx_valid = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    mem_a = 32'h0003_0010; mem_dout = 8'h00; mem_wr = 1'b1;
    cnt_m = 32'd0; snap_m = 32'd0; exp_din = 8'h00;
    exp_pop = 1'b0; exp_stop = 1'b0; exp_ovf = 1'b0;
    @(negedge clk_in);
    test_reset();
    test_ram();
    test_uart_tx();
    test_full();
    test_clock();
    test_stdin();
    test_stop_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
